conv_engine_param: RTL and testbench

Parametrised successor to the fixed four-filter convolution core. It computes `NUM_FILTERS` fixed-point dot products between one input vector held in the input RAM (dim) and per-filter weight vectors held in the filter RAM (bvm). Each saturated result is written to the output RAM (dom). It sits between the same three single-port synchronous RAMs and the `go`/`finish` control handshake, and the whole operation is started by one `go` pulse.

---
 rtl/conv_engine_param.sv | 168 ++++++++++++++++
 tb/tb_conv_engine_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/conv_engine_param.sv
// conv_engine_param: NUM_FILTERS fixed-point dot products of one input vector
// (dim RAM) against per-filter weight vectors (bvm RAM), saturated results
// written to dom RAM. Started by a single go pulse, finish is a level.
// Optional build macro: CONV_RELU_EN (clamp negative results to 0 before write).
module conv_engine_param #(
  parameter int DATA_W      = 16,
  parameter int FRAC_BITS   = 8,
  parameter int VEC_LEN     = 9,
  parameter int NUM_FILTERS = 4,
  parameter int ADDR_W      = 9,
  parameter int OUT_ADDR_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  xxx__dut__go,
  output logic                  dut__xxx__finish,
  output logic [ADDR_W-1:0]     dut__bvm__address,
  output logic                  dut__bvm__enable,
  output logic                  dut__bvm__write,
  output logic [DATA_W-1:0]     dut__bvm__data,
  input  logic [DATA_W-1:0]     bvm__dut__data,
  output logic [ADDR_W-1:0]     dut__dim__address,
  output logic                  dut__dim__enable,
  output logic                  dut__dim__write,
  output logic [DATA_W-1:0]     dut__dim__data,
  input  logic [DATA_W-1:0]     dim__dut__data,
  output logic [OUT_ADDR_W-1:0] dut__dom__address,
  output logic [DATA_W-1:0]     dut__dom__data,
  output logic                  dut__dom__enable,
  output logic                  dut__dom__write
);
  localparam int ACC_W = 2*DATA_W + $clog2(VEC_LEN);
  localparam int CNT_W = $clog2(VEC_LEN+1);
  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int F_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int SUM_W = ADDR_W + CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE} state_t;

  state_t                    r_state, w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [F_W-1:0]            r_f;
  logic [ADDR_W-1:0]         r_base;
  logic                      r_rd_vld;
  logic [IDX_W-1:0]          r_rd_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_in_buf [VEC_LEN];
  logic                      r_finish;

  logic                      w_issue, w_last, w_last_f;
  logic [SUM_W-1:0]          w_bvm_sum, w_dim_sum;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_fits;
  logic [DATA_W-1:0]         w_sat, w_result;

  // cnt runs 0..VEC_LEN: the first VEC_LEN cycles issue reads, the extra one drains the last return
  assign w_issue   = (r_cnt != CNT_W'(VEC_LEN));
  assign w_last    = !w_issue;
  assign w_last_f  = (r_f == F_W'(NUM_FILTERS-1));
  assign w_bvm_sum = SUM_W'(r_base) + SUM_W'(r_cnt);
  assign w_dim_sum = SUM_W'(r_cnt);

  assign w_prod  = (2*DATA_W)'(r_in_buf[r_rd_idx]) * (2*DATA_W)'($signed(bvm__dut__data));
  assign w_shift = r_acc >>> FRAC_BITS;
  // in range when all bits above the result sign bit agree with it
  assign w_fits  = (&w_shift[ACC_W-1:DATA_W-1]) | ~(|w_shift[ACC_W-1:DATA_W-1]);
  assign w_sat   = w_fits ? w_shift[DATA_W-1:0]
                 : (w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`ifdef CONV_RELU_EN
  assign w_result = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  assign dut__xxx__finish = r_finish;
  assign dut__bvm__write  = 1'b0;
  assign dut__bvm__data   = '0;
  assign dut__dim__write  = 1'b0;
  assign dut__dim__data   = '0;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state and RAM-facing outputs, decoded from current state
  always_comb begin
    w_next            = r_state;
    dut__bvm__address = '0;
    dut__bvm__enable  = 1'b0;
    dut__dim__address = '0;
    dut__dim__enable  = 1'b0;
    dut__dom__address = '0;
    dut__dom__data    = '0;
    dut__dom__enable  = 1'b0;
    dut__dom__write   = 1'b0;
    case (r_state)
      S_IDLE:  if (xxx__dut__go) w_next = S_LOAD;
      S_LOAD: begin
        dut__dim__enable = w_issue;
        if (w_issue) dut__dim__address = w_dim_sum[ADDR_W-1:0];
        if (w_last) w_next = S_MAC;
      end
      S_MAC: begin
        dut__bvm__enable = w_issue;
        if (w_issue) dut__bvm__address = w_bvm_sum[ADDR_W-1:0];
        if (w_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        dut__dom__address = OUT_ADDR_W'(r_f);
        dut__dom__data    = w_result;
        dut__dom__enable  = 1'b1;
        dut__dom__write   = 1'b1;
        w_next            = w_last_f ? S_IDLE : S_MAC;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: counters, input capture, accumulation, finish flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_f      <= '0;
      r_base   <= '0;
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
      r_acc    <= '0;
      r_finish <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) r_in_buf[i] <= '0;
    end else begin
      r_rd_vld <= ((r_state == S_LOAD) || (r_state == S_MAC)) && w_issue;
      r_rd_idx <= IDX_W'(r_cnt);
      case (r_state)
        S_IDLE: if (xxx__dut__go) begin
          r_finish <= 1'b0;
          r_cnt    <= '0;
        end
        S_LOAD: begin
          if (r_rd_vld) r_in_buf[r_rd_idx] <= $signed(dim__dut__data);
          if (w_last) begin
            r_cnt  <= '0;
            r_f    <= '0;
            r_base <= '0;
            r_acc  <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_MAC: begin
          if (r_rd_vld) r_acc <= r_acc + ACC_W'(w_prod);
          if (w_last) r_cnt <= '0;
          else        r_cnt <= r_cnt + 1'b1;
        end
        S_WRITE: begin
          r_acc <= '0;
          r_cnt <= '0;
          if (w_last_f) r_finish <= 1'b1;
          else begin
            r_f    <= r_f + 1'b1;
            r_base <= r_base + ADDR_W'(VEC_LEN);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_engine_param.sv
// Scoreboard bench for conv_engine_param with default parameters.
module tb_conv_engine_param;
  logic        clk = 1'b0, reset = 1'b1, go = 1'b0;
  logic        finish;
  logic [8:0]  bvm_addr, dim_addr;
  logic        bvm_en, bvm_wr, dim_en, dim_wr;
  logic [15:0] bvm_wd, dim_wd, bvm_q, dim_q;
  logic [2:0]  dom_addr;
  logic [15:0] dom_data;
  logic        dom_en, dom_wr;

  logic [15:0] bvm_mem [0:511];
  logic [15:0] dim_mem [0:511];
  logic [15:0] dom_mem [0:7];

  logic [18:0] exp_q [$];
  int bvm_log [$];
  int dim_log [$];
  int checks = 0, errors = 0, wr_cnt = 0, port_viol = 0;

`ifdef CONV_RELU_EN
  localparam logic [15:0] NEG_RES = 16'h0000;
`else
  localparam logic [15:0] NEG_RES = 16'h8000;
`endif

  conv_engine_param dut (
    .clk(clk), .reset(reset), .xxx__dut__go(go), .dut__xxx__finish(finish),
    .dut__bvm__address(bvm_addr), .dut__bvm__enable(bvm_en), .dut__bvm__write(bvm_wr),
    .dut__bvm__data(bvm_wd), .bvm__dut__data(bvm_q),
    .dut__dim__address(dim_addr), .dut__dim__enable(dim_en), .dut__dim__write(dim_wr),
    .dut__dim__data(dim_wd), .dim__dut__data(dim_q),
    .dut__dom__address(dom_addr), .dut__dom__data(dom_data),
    .dut__dom__enable(dom_en), .dut__dom__write(dom_wr)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM models
  always @(posedge clk) begin
    if (bvm_en) bvm_q <= bvm_mem[bvm_addr];
    if (dim_en) dim_q <= dim_mem[dim_addr];
    if (dom_en && dom_wr) dom_mem[dom_addr] <= dom_data;
  end

  // monitor: pops the scoreboard on every dom write, logs read addresses
  always @(negedge clk) begin
    if (bvm_wr || dim_wr || bvm_wd != 16'h0 || dim_wd != 16'h0) port_viol++;
    if (bvm_en) bvm_log.push_back(int'(bvm_addr));
    if (dim_en) dim_log.push_back(int'(dim_addr));
    if (dom_en && dom_wr) begin
      logic [18:0] e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dom_unexpected: got addr=%0d data=%h, none expected", dom_addr, dom_data);
      end else begin
        e = exp_q.pop_front();
        if ({dom_addr, dom_data} !== e) begin
          errors++;
          $display("FAIL dom_write: got addr=%0d data=%h expected addr=%0d data=%h",
                   dom_addr, dom_data, e[18:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: weights (f+1)*1.0; 1: all 0x7FFF; 2: all 0x8000; 3: alternating +1.0/-1.0
  task automatic set_mem(input logic [15:0] inval, input int mode);
    for (int i = 0; i < 9; i++) dim_mem[i] = inval;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 9; i++)
        case (mode)
          0: bvm_mem[f*9+i] = 16'((f+1)*256);
          1: bvm_mem[f*9+i] = 16'h7FFF;
          2: bvm_mem[f*9+i] = 16'h8000;
          default: bvm_mem[f*9+i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
        endcase
  endtask

  task automatic run(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                     input logic [15:0] e2, input logic [15:0] e3,
                     input int busy_at, input int rst_at);
    int  lat;
    bit  done, ok;
    lat = -1; done = 0;
    exp_q.push_back({3'd0, e0}); exp_q.push_back({3'd1, e1});
    exp_q.push_back({3'd2, e2}); exp_q.push_back({3'd3, e3});
    bvm_log.delete(); dim_log.delete(); wr_cnt = 0; port_viol = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    chk({tag, "_finish_clr"}, 32'(finish), 32'd0);
    for (int c = 1; c <= 200 && !done; c++) begin
      @(posedge clk); #1;
      if (c == busy_at - 1) go = 1'b1;
      if (c == busy_at)     go = 1'b0;
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_outs"}, 32'(|{finish, bvm_addr, bvm_en, bvm_wr, bvm_wd, dim_addr, dim_en,
                                    dim_wr, dim_wd, dom_addr, dom_data, dom_en, dom_wr}), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_rst_wr_cnt"}, 32'(wr_cnt), 32'd1);
        chk({tag, "_dom0_kept"}, 32'(dom_mem[0]), 32'(e0));
        reset = 1'b0;
        done = 1;
      end else if (finish) begin
        lat = c;
        done = 1;
      end
    end
    if (rst_at == 0) begin
      chk({tag, "_latency"}, 32'(lat), 32'd54);
      chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd4);
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      ok = (bvm_log.size() == 36);
      foreach (bvm_log[k]) if (bvm_log[k] != k) ok = 0;
      chk({tag, "_bvm_seq"}, 32'(ok), 32'd1);
      ok = (dim_log.size() == 9);
      foreach (dim_log[k]) if (dim_log[k] != k) ok = 0;
      chk({tag, "_dim_seq"}, 32'(ok), 32'd1);
      chk({tag, "_port_wr"}, 32'(port_viol), 32'd0);
      repeat (5) @(posedge clk);
      #1 chk({tag, "_finish_hold"}, 32'(finish), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin bvm_mem[i] = '0; dim_mem[i] = '0; end
    for (int i = 0; i < 8; i++) dom_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_finish", 32'(finish), 32'd0);
    chk("reset_outs", 32'(|{bvm_addr, bvm_en, bvm_wr, bvm_wd, dim_addr, dim_en, dim_wr, dim_wd,
                          dom_addr, dom_data, dom_en, dom_wr}), 32'd0);
    reset = 1'b0;

    set_mem(16'h0100, 0);
    run("nominal", 16'h0900, 16'h1200, 16'h1B00, 16'h2400, 0, 0);
    set_mem(16'h7FFF, 1);
    run("pos_sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0);
    set_mem(16'h7FFF, 2);
    run("neg_sat", NEG_RES, NEG_RES, NEG_RES, NEG_RES, 0, 0);
    set_mem(16'h0100, 3);
    run("mixed", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0);
    set_mem(16'h0100, 0);
    run("busy_go", 16'h0900, 16'h1200, 16'h1B00, 16'h2400, 20, 0);
    run("rst_mid", 16'h0900, 16'h1200, 16'h1B00, 16'h2400, 0, 25);
    run("rerun", 16'h0900, 16'h1200, 16'h1B00, 16'h2400, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
